// File: rtl/led_sweep_pkg.sv
// Shared types and seed constants for the LED sweep pattern generator.
package led_sweep_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [31:0] SEED_SHIFT  = 32'd1;
  localparam logic [31:0] SEED_BOUNCE = 32'd1;
  localparam logic [31:0] SEED_COUNT  = 32'd0;
  localparam logic [31:0] SEED_FILL   = 32'd0;

  function automatic logic [31:0] mode_seed(mode_t m);
    case (m)
      MODE_SHIFT:  return SEED_SHIFT;
      MODE_BOUNCE: return SEED_BOUNCE;
      MODE_COUNT:  return SEED_COUNT;
      default:     return SEED_FILL;
    endcase
  endfunction

endpackage

// File: rtl/led_sweep_tick_div.sv
// Prescaler: free-running advance every div+1 cycles, or single steps while disabled.
module tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             clr,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             adv
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // >= rather than == so lowering div below the running count fires at once
  assign hit = (cnt_q >= div);
  assign adv = !clr && (en ? hit : step);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr || !en || hit) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_sweep.sv
// LED sweep: four selectable WIDTH-bit patterns stepped by a prescaled advance.
module led_sweep
  import led_sweep_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             step,
  output logic [WIDTH-1:0] pattern,
  output logic             tick,
  output logic             wrap
);

  mode_t            mode_in, mode_q;
  dir_t             dir_q, dir_d, adv_dir;
  logic [WIDTH-1:0] pattern_q, pattern_d, adv_pat, cur_seed;
  logic             tick_q, tick_d, wrap_q, wrap_d;
  logic             reload, adv;

  assign mode_in  = mode_t'(mode);
  assign reload   = (mode_in != mode_q);
  assign cur_seed = WIDTH'(mode_seed(mode_q));

  tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .clr    (reload),
    .step   (step),
    .div    (div),
    .adv    (adv)
  );

  // Pattern after one advance in the current mode
  always_comb begin
    adv_pat = pattern_q;
    adv_dir = dir_q;
    case (mode_q)
      MODE_SHIFT:  adv_pat = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
      MODE_BOUNCE: begin
        adv_pat = (dir_q == DIR_UP) ? (pattern_q << 1) : (pattern_q >> 1);
        if (adv_pat[WIDTH-1])  adv_dir = DIR_DOWN;
        else if (adv_pat[0])   adv_dir = DIR_UP;
      end
      MODE_COUNT:  adv_pat = pattern_q + WIDTH'(1);
      MODE_FILL:   adv_pat = (&pattern_q) ? '0 : {pattern_q[WIDTH-2:0], 1'b1};
      default:     adv_pat = pattern_q;
    endcase
  end

  always_comb begin
    pattern_d = pattern_q;
    dir_d     = dir_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    if (reload) begin
      pattern_d = WIDTH'(mode_seed(mode_in));
      dir_d     = DIR_UP;
    end else if (adv) begin
      pattern_d = adv_pat;
      dir_d     = adv_dir;
      tick_d    = 1'b1;
      wrap_d    = (adv_pat == cur_seed);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pattern_q <= WIDTH'(1);
      mode_q    <= MODE_SHIFT;
      dir_q     <= DIR_UP;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      mode_q    <= mode_in;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign pattern = pattern_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_led_sweep.sv
// Bench for led_sweep: directed table, corner sequences and random run vs. an index-based model.
module tb_led_sweep;

  logic        clk = 1'b0;
  logic        resetn = 1'b0, en = 1'b0, step = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] div = 16'd0;
  logic [7:0]  pat8;
  logic        tick8, wrap8;
  logic [3:0]  pat4;
  logic        tick4, wrap4;

  always #5 clk = ~clk;

  led_sweep #(.WIDTH(8), .DIV_W(16)) u8 (
    .clk(clk), .resetn(resetn), .en(en), .mode(mode), .div(div), .step(step),
    .pattern(pat8), .tick(tick8), .wrap(wrap8));

  led_sweep #(.WIDTH(4), .DIV_W(16)) u4 (
    .clk(clk), .resetn(resetn), .en(en), .mode(mode), .div(div), .step(step),
    .pattern(pat4), .tick(tick4), .wrap(wrap4));

  int checks = 0, failures = 0;

  // Model: pattern is a pure function of (mode, advance index k); k wraps at the mode period
  int m_mode = 0, m_cnt = 0;
  int m_k[2];
  bit m_tick, m_wrap[2];
  int wid[2] = '{8, 4};

  function automatic int period(int m, int w);
    case (m)
      0:       return w;
      1:       return 2 * w - 2;
      2:       return 1 << w;
      default: return w + 1;
    endcase
  endfunction

  function automatic longint unsigned ref_pat(int m, int w, int k);
    int p;
    case (m)
      0:       return 64'd1 << k;
      1:       begin p = (k < w) ? k : (2 * w - 2 - k); return 64'd1 << p; end
      2:       return 64'(k);
      default: return (64'd1 << k) - 64'd1;
    endcase
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit adv;
    if (!resetn) begin
      m_mode = 0; m_cnt = 0; m_tick = 0;
      for (int i = 0; i < 2; i++) begin m_k[i] = 0; m_wrap[i] = 0; end
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_cnt = 0; m_tick = 0;
      for (int i = 0; i < 2; i++) begin m_k[i] = 0; m_wrap[i] = 0; end
    end else begin
      adv = en ? (m_cnt >= int'(div)) : step;
      if (en) m_cnt = adv ? 0 : m_cnt + 1;
      else    m_cnt = 0;
      m_tick = adv;
      for (int i = 0; i < 2; i++) begin
        if (adv) m_k[i] = (m_k[i] + 1) % period(m_mode, wid[i]);
        m_wrap[i] = adv && (m_k[i] == 0);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pat8",  64'(pat8),  ref_pat(m_mode, 8, m_k[0]));
    chk("tick8", 64'(tick8), 64'(m_tick));
    chk("wrap8", 64'(wrap8), 64'(m_wrap[0]));
    chk("pat4",  64'(pat4),  ref_pat(m_mode, 4, m_k[1]));
    chk("tick4", 64'(tick4), 64'(m_tick));
    chk("wrap4", 64'(wrap4), 64'(m_wrap[1]));
  endtask

  typedef struct {
    bit       rn, en;
    bit [1:0] mode;
    int       div;
    bit       step;
    bit [7:0] pat;
    bit       tick, wrap;
  } vec_t;

  vec_t tbl[18];
  bit [7:0] bounce_exp[14];
  int n, wraps;
  bit [3:0] prev4;
  bit seen;

  initial begin
    //            rn en md div st  pat   tk wr
    tbl[0]  = '{0, 0, 0, 2, 0, 8'h01, 0, 0};
    tbl[1]  = '{1, 1, 0, 2, 0, 8'h01, 0, 0};
    tbl[2]  = '{1, 1, 0, 2, 0, 8'h01, 0, 0};
    tbl[3]  = '{1, 1, 0, 2, 0, 8'h02, 1, 0};
    tbl[4]  = '{1, 1, 0, 2, 0, 8'h02, 0, 0};
    tbl[5]  = '{1, 1, 0, 2, 0, 8'h02, 0, 0};
    tbl[6]  = '{1, 1, 0, 2, 0, 8'h04, 1, 0};
    tbl[7]  = '{1, 0, 2, 2, 0, 8'h00, 0, 0};
    tbl[8]  = '{1, 0, 2, 2, 1, 8'h01, 1, 0};
    tbl[9]  = '{1, 0, 2, 2, 0, 8'h01, 0, 0};
    tbl[10] = '{1, 0, 2, 2, 1, 8'h02, 1, 0};
    tbl[11] = '{1, 0, 2, 2, 0, 8'h02, 0, 0};
    tbl[12] = '{1, 0, 2, 2, 1, 8'h03, 1, 0};
    tbl[13] = '{1, 0, 2, 2, 0, 8'h03, 0, 0};
    tbl[14] = '{1, 0, 2, 2, 1, 8'h04, 1, 0};
    tbl[15] = '{1, 0, 2, 2, 1, 8'h05, 1, 0};
    tbl[16] = '{1, 1, 2, 5, 1, 8'h05, 0, 0};
    tbl[17] = '{1, 1, 2, 5, 1, 8'h05, 0, 0};
    bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    @(negedge clk);
    foreach (tbl[i]) begin
      resetn = tbl[i].rn; en = tbl[i].en; mode = tbl[i].mode;
      div = 16'(tbl[i].div); step = tbl[i].step;
      cyc();
      chk($sformatf("vec%0d_pat", i),  64'(pat8),  64'(tbl[i].pat));
      chk($sformatf("vec%0d_tick", i), 64'(tick8), 64'(tbl[i].tick));
      chk($sformatf("vec%0d_wrap", i), 64'(wrap8), 64'(tbl[i].wrap));
    end

    // SHIFT full revolution: wrap exactly on the return to 01
    resetn = 0; step = 0; mode = 0; cyc();
    resetn = 1; en = 1; div = 2;
    wraps = 0;
    for (int i = 0; i < 27; i++) begin
      cyc();
      if (tick8) chk("shift_wrap_at_01", 64'(wrap8), 64'(pat8 == 8'h01));
      if (wrap8) wraps++;
    end
    chk("shift_wrap_count", 64'(wraps), 64'd1);

    // BOUNCE with mode set across reset release: reload first, then one full period
    resetn = 0; mode = 1; div = 0; cyc();
    resetn = 1; cyc();
    chk("bounce_reload_pat", 64'(pat8), 64'h01);
    chk("bounce_reload_tick", 64'(tick8), 64'd0);
    for (int i = 0; i < 14; i++) begin
      cyc();
      chk($sformatf("bounce%0d_pat", i), 64'(pat8), 64'(bounce_exp[i]));
      chk($sformatf("bounce%0d_wrap", i), 64'(wrap8), 64'(i == 13));
    end

    // Mode switch coinciding with an advance request: reload wins
    mode = 3; div = 2; cyc();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin cyc(); if (m_cnt == 2) seen = 1; end
    chk("req_pending_reached", 64'(seen), 64'd1);
    mode = 2; cyc();
    chk("switch_pat", 64'(pat8), 64'h00);
    chk("switch_tick", 64'(tick8), 64'd0);
    n = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin cyc(); n++; if (tick8) seen = 1; end
    chk("resume_latency", 64'(n), 64'd3);

    // Lowering div below the running count fires next cycle; reset mid-run
    div = 10; seen = 0;
    for (int i = 0; i < 25 && !seen; i++) begin cyc(); if (m_cnt == 7) seen = 1; end
    chk("cnt7_reached", 64'(seen), 64'd1);
    div = 3; cyc();
    chk("div_lower_tick", 64'(tick8), 64'd1);
    cyc(); cyc();
    resetn = 0; cyc();
    chk("rst_pat", 64'(pat8), 64'h01);
    chk("rst_tick", 64'(tick8), 64'd0);
    chk("rst_wrap", 64'(wrap8), 64'd0);

    // 4-bit COUNT at div=0: wrap only on F->0
    resetn = 1; mode = 2; div = 0; en = 1; cyc();
    wraps = 0; prev4 = pat4;
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("count4_wrap_F0", 64'(wrap4), 64'(prev4 == 4'hF && pat4 == 4'h0));
      if (wrap4) wraps++;
      prev4 = pat4;
    end
    chk("count4_wrap_count", 64'(wraps), 64'd2);

    // Random run against the model
    for (int i = 0; i < 2000; i++) begin
      resetn = ($urandom_range(0, 99) != 0);
      en     = ($urandom_range(0, 3) != 0);
      step   = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  div  = 16'($urandom_range(0, 5));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_sweep.md
LED_SWEEP -- requirements
Module: led_sweep

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the pattern width (legal 2..32).
REQ-002 The block SHALL have parameter DIV_W, default 16, giving the prescaler width.
REQ-003 The block SHALL have port clk, input, 1, as the single clock; all logic on posedge.
REQ-004 The block SHALL have port resetn, input, 1, as the reset, which is synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1, which enables free-running advance.
REQ-006 The block SHALL have port mode, input, 2, to select the pattern mode.
REQ-007 The block SHALL have port div, input, DIV_W, giving the advance period of div+1 clk cycles.
REQ-008 The block SHALL have port step, input, 1, which requests a single advance while en=0.
REQ-009 The block SHALL have port pattern, output, WIDTH, driven from a register.
REQ-010 The block SHALL have port tick, output, 1, a registered pulse in the cycle pattern changes by an advance.
REQ-011 The block SHALL have port wrap, output, 1, a registered pulse in the cycle pattern returns to its seed by an advance.

Function
REQ-012 Modes SHALL be:
- 0 SHIFT: one-hot rotate left, MSB->bit0, seed 1.
- 1 BOUNCE: one-hot up to MSB, then down to bit0, repeat, seed 1, direction up.
- 2 COUNT: binary increment modulo 2^WIDTH, seed 0.
- 3 FILL: thermometer 0->1->3->...->all-ones->0, seed 0.
REQ-013 The prescaler count cnt SHALL increment each cycle while en=1; when cnt>=div it SHALL reset to 0 and raise an advance request.
REQ-014 While en=0, cnt SHALL be held at 0, and each cycle with step=1 SHALL raise one advance request.
REQ-015 step SHALL be ignored while en=1.
REQ-016 An advance request in cycle N SHALL update pattern, tick=1 and wrap (if applicable) in cycle N+1 (one-cycle latency).
REQ-017 tick and wrap SHALL be 0 in every cycle without an advance.
REQ-018 In BOUNCE, direction SHALL flip to down on reaching MSB and to up on reaching bit0; the end bits SHALL be shown once per pass, giving a period of 2*WIDTH-2 advances.
REQ-019 wrap SHALL assert as follows:
- SHIFT: on MSB->bit0.
- BOUNCE: on bit1->bit0.
- COUNT: on all-ones->0.
- FILL: on all-ones->0.
REQ-020 mode SHALL be sampled into mode_q each cycle; when mode!=mode_q, the next cycle SHALL reload pattern with the new mode's seed, set direction up, clear cnt, and drive tick=0 and wrap=0.
REQ-021 A reload SHALL take priority over a simultaneous advance request, and that advance SHALL be discarded.
REQ-022 With div=0 and en=1, the block SHALL advance every cycle.
REQ-023 If div is lowered below the current cnt, the next cycle SHALL advance, via the >= compare.
REQ-024 All arithmetic SHALL be unsigned, and the COUNT increment SHALL truncate to WIDTH.

Reset
REQ-025 When resetn=0 at posedge, the block SHALL set pattern=1, mode_q=0 (SHIFT), direction=up, cnt=0, tick=0, wrap=0.
REQ-026 Reset SHALL override any in-progress count, advance or reload.
REQ-027 If mode!=0 when reset releases, the REQ-020 reload SHALL occur in the first cycle after release.

Structure
REQ-028 Mode encodings, the 2-bit mode type, and per-mode seed constants SHALL be defined in package led_sweep_pkg.
REQ-029 The prescaler SHALL be a sub-module tick_div, with inputs clk, resetn, en, clr, step, div and a 1-cycle output adv.
REQ-030 The pattern-next logic SHALL be a single case on mode_q, and the block SHALL contain no other sub-modules.

Verification
REQ-031 WIDTH=8, mode=0, div=2, en=1 -> tick every 3 cycles; pattern 01,02,04,...,80,01; wrap coincides with 80->01.
REQ-032 mode=1, div=0, en=1 -> pattern 01,02,...,80,40,...,02,01 (period 14); wrap on 02->01 only.
REQ-033 mode=2, en=0, three single-cycle step pulses, then step held 2 cycles -> pattern 0,1,2,3,4,5; step with en=1 -> no extra advance.
REQ-034 mode=3 running, then switch to mode=2 in the same cycle as an advance request -> next cycle pattern=00, tick=0; advances resume after div+1 cycles.
REQ-035 Running with cnt=7, div changed 10->3 -> advance in the next cycle; then reset asserted mid-run -> pattern=01, tick=0, wrap=0 the following cycle.
REQ-036 mode=2, WIDTH=4, div=0 -> pattern F->0 with wrap=1; no other cycle wraps.
